// File: rtl/regfile_port_ctrl_pkg.sv
// Shared definitions for the register file port controller.
// Contents: FSM state encoding, the gp/sp register indices, default boot
// values, and the boot_value() helper used by the init sweep.
package regfile_ctrl_pkg;

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DATA_W = 32;

    localparam int unsigned GP_INDEX = 28;
    localparam int unsigned SP_INDEX = 29;

    localparam logic [DATA_W-1:0] GP_INIT_DEFAULT = 32'h0000_1800;
    localparam logic [DATA_W-1:0] SP_INIT_DEFAULT = 32'h0000_2ffe;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_DBG  = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    // Boot value of register idx: gp and sp get their init values, all others 0.
    function automatic logic [DATA_W-1:0] boot_value(
        input logic [IDX_W-1:0]  idx,
        input logic [DATA_W-1:0] gp_init,
        input logic [DATA_W-1:0] sp_init
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (idx == IDX_W'(GP_INDEX)) begin
            v = gp_init;
        end else if (idx == IDX_W'(SP_INDEX)) begin
            v = sp_init;
        end
        return v;
    endfunction

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// Debug-host access port: 4-phase req/ack handshake that reads or writes one
// register per transaction.
// Ports: dbg_req, dbg_we, dbg_addr, dbg_wdata (host -> controller);
//        dbg_ack, dbg_rdata (controller -> host).
// Modports: master = debug host, slave = register file port controller.
interface regfile_port_ctrl_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
);

    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [WIDTH-1:0]      dbg_wdata;
    logic                  dbg_ack;
    logic [WIDTH-1:0]      dbg_rdata;

    modport master (
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata
    );

    modport slave (
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata
    );

endinterface

// File: rtl/regfile_port_ctrl.sv
// Owns the write port and read port 1 of the 32x32 MIPS register file.
// After reset it sweeps every register to its boot value, then passes CPU
// writeback through combinationally, and slots in one-cycle debug-host
// accesses (stalling the CPU for that cycle).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_reg_write/_write_register/_write_data/_read_register1   CPU side
//   rf_read_data1            register file read port 1 data
//   rf_reg_write/_write_register/_write_data/_read_register1    to register file
//   cpu_stall, init_busy     CPU hold request, boot sweep in progress
//   dbg                      debug-host port (slave modport)
module regfile_port_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned     WIDTH      = 32,
    parameter int unsigned     ADDR_WIDTH = 5,
    parameter int unsigned     NUM        = 32,
    parameter logic [WIDTH-1:0] GP_INIT   = 32'h0000_1800,
    parameter logic [WIDTH-1:0] SP_INIT   = 32'h0000_2ffe
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_reg_write,
    input  logic [ADDR_WIDTH-1:0] cpu_write_register,
    input  logic [WIDTH-1:0]      cpu_write_data,
    input  logic [ADDR_WIDTH-1:0] cpu_read_register1,
    input  logic [WIDTH-1:0]      rf_read_data1,
    output logic                  rf_reg_write,
    output logic [ADDR_WIDTH-1:0] rf_write_register,
    output logic [WIDTH-1:0]      rf_write_data,
    output logic [ADDR_WIDTH-1:0] rf_read_register1,
    output logic                  cpu_stall,
    output logic                  init_busy,
    regfile_port_ctrl_if.slave    dbg
);

    localparam int unsigned CNT_W = (NUM > 1) ? $clog2(NUM) : 1;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic                  accept_c;
    logic                  cap_we;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [WIDTH-1:0]      cap_wdata;
    logic                  ack_q;
    logic [WIDTH-1:0]      rdata_q;

    // CPU writeback has priority; a pending debug request simply waits.
    assign accept_c = (state == ST_IDLE) && dbg.dbg_req && !cpu_reg_write;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (cnt == CNT_W'(NUM - 1)) state_nxt = ST_IDLE;
            ST_IDLE: if (accept_c)               state_nxt = ST_DBG;
            ST_DBG:                              state_nxt = ST_ACK;
            ST_ACK:  if (!dbg.dbg_req)           state_nxt = ST_IDLE;
            default:                             state_nxt = ST_INIT;
        endcase
    end

    // Output logic: CPU pass-through by default, overridden in INIT and DBG
    always_comb begin
        rf_reg_write      = cpu_reg_write;
        rf_write_register = cpu_write_register;
        rf_write_data     = cpu_write_data;
        rf_read_register1 = cpu_read_register1;
        cpu_stall         = 1'b0;
        init_busy         = 1'b0;
        case (state)
            ST_INIT: begin
                rf_reg_write      = 1'b1;
                rf_write_register = ADDR_WIDTH'(cnt);
                rf_write_data     = WIDTH'(boot_value(IDX_W'(cnt), DATA_W'(GP_INIT),
                                                      DATA_W'(SP_INIT)));
                cpu_stall         = 1'b1;
                init_busy         = 1'b1;
            end
            ST_DBG: begin
                cpu_stall = 1'b1;
                if (cap_we) begin
                    rf_reg_write      = 1'b1;
                    rf_write_register = cap_addr;
                    rf_write_data     = cap_wdata;
                end else begin
                    rf_reg_write      = 1'b0;
                    rf_read_register1 = cap_addr;
                end
            end
            default: ;
        endcase
    end

    // Init counter, request capture and debug response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (state == ST_INIT && cnt != CNT_W'(NUM - 1)) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (accept_c) begin
                cap_we    <= dbg.dbg_we;
                cap_addr  <= dbg.dbg_addr;
                cap_wdata <= dbg.dbg_wdata;
            end
            if (state == ST_DBG) begin
                ack_q <= 1'b1;
                if (!cap_we) begin
                    rdata_q <= rf_read_data1;
                end
            end else if (state == ST_ACK && !dbg.dbg_req) begin
                ack_q <= 1'b0;
            end
        end
    end

    assign dbg.dbg_ack   = ack_q;
    assign dbg.dbg_rdata = rdata_q;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: behavioural register file (negedge write,
// combinational read, r0 hardwired to 0), directed vector table for the CPU
// pass-through, and hand-written sequences for sweep, debug and reset cases.
module tb_regfile_port_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_reg_write;
    logic [4:0]  cpu_write_register;
    logic [31:0] cpu_write_data;
    logic [4:0]  cpu_read_register1;
    logic [31:0] rf_read_data1;
    logic        rf_reg_write;
    logic [4:0]  rf_write_register;
    logic [31:0] rf_write_data;
    logic [4:0]  rf_read_register1;
    logic        cpu_stall;
    logic        init_busy;

    int total;
    int bad;

    logic [31:0] rf_m [32];

    regfile_port_ctrl_if #(.WIDTH(32), .ADDR_WIDTH(5)) dbg_if ();

    regfile_port_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .cpu_reg_write      (cpu_reg_write),
        .cpu_write_register (cpu_write_register),
        .cpu_write_data     (cpu_write_data),
        .cpu_read_register1 (cpu_read_register1),
        .rf_read_data1      (rf_read_data1),
        .rf_reg_write       (rf_reg_write),
        .rf_write_register  (rf_write_register),
        .rf_write_data      (rf_write_data),
        .rf_read_register1  (rf_read_register1),
        .cpu_stall          (cpu_stall),
        .init_busy          (init_busy),
        .dbg                (dbg_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model
    always @(negedge clk) begin
        if (rf_reg_write === 1'b1) begin
            rf_m[rf_write_register] <= (rf_write_register == 5'd0) ? 32'h0 : rf_write_data;
        end
    end
    assign rf_read_data1 = rf_m[rf_read_register1];

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [4:0]  rreg;
        logic        exp_we;
        logic [4:0]  exp_wreg;
        logic [31:0] exp_wdata;
        logic [4:0]  exp_rreg;
    } vec_t;

    vec_t vecs [4];

    function automatic logic [31:0] exp_boot(input int i);
        if (i == 28) return 32'h0000_1800;
        if (i == 29) return 32'h0000_2ffe;
        return 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects to be entered in the first INIT cycle (cnt=0)
    task automatic check_sweep();
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("sweep_busy[%0d]", i), 32'(init_busy), 32'd1);
            chk($sformatf("sweep_stall[%0d]", i), 32'(cpu_stall), 32'd1);
            chk($sformatf("sweep_we[%0d]", i), 32'(rf_reg_write), 32'd1);
            chk($sformatf("sweep_idx[%0d]", i), 32'(rf_write_register), 32'(i));
            chk($sformatf("sweep_data[%0d]", i), rf_write_data, exp_boot(i));
            step();
        end
        chk("sweep_done_busy", 32'(init_busy), 32'd0);
        chk("sweep_done_stall", 32'(cpu_stall), 32'd0);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("rf_boot[%0d]", i), rf_m[i], exp_boot(i));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd3,  1'b1, 5'd5,  32'hDEAD_BEEF, 5'd3};
        vecs[1] = '{1'b0, 5'd9,  32'h0000_0011, 5'd28, 1'b0, 5'd9,  32'h0000_0011, 5'd28};
        vecs[2] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd29, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd29};
        vecs[3] = '{1'b1, 5'd0,  32'h0000_A5A5, 5'd0,  1'b1, 5'd0,  32'h0000_A5A5, 5'd0};

        rst                = 1'b1;
        cpu_reg_write      = 1'b0;
        cpu_write_register = '0;
        cpu_write_data     = '0;
        cpu_read_register1 = '0;
        dbg_if.dbg_req     = 1'b0;
        dbg_if.dbg_we      = 1'b0;
        dbg_if.dbg_addr    = '0;
        dbg_if.dbg_wdata   = '0;

        // Reset state
        step();
        chk("rst_busy", 32'(init_busy), 32'd1);
        chk("rst_stall", 32'(cpu_stall), 32'd1);
        chk("rst_ack", 32'(dbg_if.dbg_ack), 32'd0);
        chk("rst_rdata", dbg_if.dbg_rdata, 32'h0);
        step();
        rst = 1'b0;
        check_sweep();

        // CPU pass-through vectors
        for (int v = 0; v < 4; v++) begin
            cpu_reg_write      = vecs[v].we;
            cpu_write_register = vecs[v].wreg;
            cpu_write_data     = vecs[v].wdata;
            cpu_read_register1 = vecs[v].rreg;
            #1;
            chk($sformatf("pt_we[%0d]", v), 32'(rf_reg_write), 32'(vecs[v].exp_we));
            chk($sformatf("pt_wreg[%0d]", v), 32'(rf_write_register), 32'(vecs[v].exp_wreg));
            chk($sformatf("pt_wdata[%0d]", v), rf_write_data, vecs[v].exp_wdata);
            chk($sformatf("pt_rreg[%0d]", v), 32'(rf_read_register1), 32'(vecs[v].exp_rreg));
            chk($sformatf("pt_stall[%0d]", v), 32'(cpu_stall), 32'd0);
            step();
        end
        cpu_reg_write = 1'b0;
        chk("rf_r5", rf_m[5], 32'hDEAD_BEEF);

        // Debug write r7
        dbg_if.dbg_req   = 1'b1;
        dbg_if.dbg_we    = 1'b1;
        dbg_if.dbg_addr  = 5'd7;
        dbg_if.dbg_wdata = 32'h1234_5678;
        #1;
        chk("dw_idle_stall", 32'(cpu_stall), 32'd0);
        step();
        chk("dw_dbg_stall", 32'(cpu_stall), 32'd1);
        chk("dw_dbg_we", 32'(rf_reg_write), 32'd1);
        chk("dw_dbg_wreg", 32'(rf_write_register), 32'd7);
        chk("dw_dbg_wdata", rf_write_data, 32'h1234_5678);
        chk("dw_dbg_ack", 32'(dbg_if.dbg_ack), 32'd0);
        step();
        chk("dw_ack", 32'(dbg_if.dbg_ack), 32'd1);
        chk("dw_ack_stall", 32'(cpu_stall), 32'd0);
        chk("dw_rdata_kept", dbg_if.dbg_rdata, 32'h0);
        dbg_if.dbg_req = 1'b0;
        step();
        chk("dw_ack_low", 32'(dbg_if.dbg_ack), 32'd0);
        chk("rf_r7", rf_m[7], 32'h1234_5678);

        // Debug read r7
        dbg_if.dbg_req   = 1'b1;
        dbg_if.dbg_we    = 1'b0;
        dbg_if.dbg_wdata = 32'h0BAD_0BAD;
        step();
        chk("dr_dbg_stall", 32'(cpu_stall), 32'd1);
        chk("dr_dbg_we", 32'(rf_reg_write), 32'd0);
        chk("dr_dbg_rreg", 32'(rf_read_register1), 32'd7);
        step();
        chk("dr_ack", 32'(dbg_if.dbg_ack), 32'd1);
        chk("dr_rdata", dbg_if.dbg_rdata, 32'h1234_5678);
        dbg_if.dbg_req = 1'b0;
        step();
        chk("dr_ack_low", 32'(dbg_if.dbg_ack), 32'd0);
        chk("dr_rdata_hold", dbg_if.dbg_rdata, 32'h1234_5678);

        // Contention: CPU writeback blocks the debug request for 3 cycles
        cpu_reg_write      = 1'b1;
        cpu_write_register = 5'd10;
        cpu_write_data     = 32'hCAFE_F00D;
        dbg_if.dbg_req     = 1'b1;
        dbg_if.dbg_we      = 1'b1;
        dbg_if.dbg_addr    = 5'd11;
        dbg_if.dbg_wdata   = 32'h0000_0055;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("ct_stall[%0d]", c), 32'(cpu_stall), 32'd0);
            chk($sformatf("ct_wreg[%0d]", c), 32'(rf_write_register), 32'd10);
            step();
        end
        cpu_reg_write = 1'b0;
        #1;
        chk("ct_fall_stall", 32'(cpu_stall), 32'd0);
        step();
        chk("ct_dbg_stall", 32'(cpu_stall), 32'd1);
        chk("ct_dbg_wreg", 32'(rf_write_register), 32'd11);
        step();

        // Handshake hold: request stays high after ack
        for (int h = 0; h < 5; h++) begin
            chk($sformatf("hs_ack[%0d]", h), 32'(dbg_if.dbg_ack), 32'd1);
            chk($sformatf("hs_stall[%0d]", h), 32'(cpu_stall), 32'd0);
            chk($sformatf("hs_we[%0d]", h), 32'(rf_reg_write), 32'd0);
            step();
        end
        dbg_if.dbg_req = 1'b0;
        step();
        chk("hs_ack_low", 32'(dbg_if.dbg_ack), 32'd0);
        chk("hs_idle_stall", 32'(cpu_stall), 32'd0);
        chk("rf_r10", rf_m[10], 32'hCAFE_F00D);
        chk("rf_r11", rf_m[11], 32'h0000_0055);

        // Reset in the middle of a debug write
        dbg_if.dbg_req   = 1'b1;
        dbg_if.dbg_we    = 1'b1;
        dbg_if.dbg_addr  = 5'd3;
        dbg_if.dbg_wdata = 32'hFFFF_FFFF;
        step();
        chk("rm_dbg_stall", 32'(cpu_stall), 32'd1);
        rst = 1'b1;
        step();
        chk("rm_busy", 32'(init_busy), 32'd1);
        chk("rm_ack", 32'(dbg_if.dbg_ack), 32'd0);
        chk("rm_rdata", dbg_if.dbg_rdata, 32'h0);
        chk("rm_wreg", 32'(rf_write_register), 32'd0);
        rst            = 1'b0;
        dbg_if.dbg_req = 1'b0;
        check_sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
